// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage (master) and
// the multi-cycle data memory (slave).
interface mem_wb_stage_if #(
    parameter int ADDR_W = 8
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: one register-file write per result-producing
// instruction, LD/ST over a req/ack data memory with timeout, flag latch and HLT.
module mem_wb_stage #(
    parameter int ADDR_W  = 8,
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ex,
    input  logic [5:0]        op_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [15:0]       ans_ex,
    input  logic [15:0]       DM_data,
    input  logic [1:0]        flag_ex,
    output logic              stall,
    mem_wb_stage_if.master    mem,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [15:0]       wb_data,
    output logic [1:0]        flag_wb,
    output logic              halt,
    output logic              mem_err
);

    localparam logic [5:0] OP_LD  = 6'h14;
    localparam logic [5:0] OP_ST  = 6'h15;
    localparam logic [5:0] OP_HLT = 6'h11;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WB,
        S_HALTED
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [REG_AW-1:0] rd_q;
    logic [15:0]       rdata_q;
    logic              is_wb, is_mem, is_hlt;
    logic              accept, ack_hit, timed_out;

    always_comb begin
        is_wb = 1'b0;
        case (op_ex)
            6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h16, 6'h19, 6'h1A, 6'h1B: is_wb = 1'b1;
            default:                    is_wb = 1'b0;
        endcase
    end

    assign is_mem    = (op_ex == OP_LD) || (op_ex == OP_ST);
    assign is_hlt    = (op_ex == OP_HLT);
    assign accept    = valid_ex && (state == S_IDLE);
    assign cnt_inc   = cnt + 1'b1;
    assign ack_hit   = (state == S_ACCESS) && mem.mem_ack;
    // The abort fires on the TIMEOUT-th ACCESS cycle; an ack in that same cycle takes priority.
    assign timed_out = (state == S_ACCESS) && !mem.mem_ack && (cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept && is_mem)      next_state = S_ACCESS;
                else if (accept && is_hlt) next_state = S_HALTED;
            end
            S_ACCESS: begin
                if (ack_hit)        next_state = mem.mem_we ? S_IDLE : S_WB;
                else if (timed_out) next_state = S_IDLE;
            end
            S_WB:     next_state = S_IDLE;
            S_HALTED: next_state = S_HALTED;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        stall = (state != S_IDLE) || (accept && (is_mem || is_hlt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_en         <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            flag_wb       <= '0;
            halt          <= 1'b0;
            mem_err       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            cnt           <= '0;
            rd_q          <= '0;
            rdata_q       <= '0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        flag_wb <= flag_ex;
                        if (is_wb) begin
                            wb_en   <= 1'b1;
                            wb_addr <= rd_ex;
                            wb_data <= ans_ex;
                        end else if (is_mem) begin
                            rd_q          <= rd_ex;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= (op_ex == OP_ST);
                            mem.mem_addr  <= ans_ex[ADDR_W-1:0];
                            mem.mem_wdata <= DM_data;
                            cnt           <= '0;
                        end else if (is_hlt) begin
                            halt <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (ack_hit) begin
                        mem.mem_req <= 1'b0;
                        cnt         <= '0;
                        if (!mem.mem_we) rdata_q <= mem.mem_rdata;
                    end else if (timed_out) begin
                        mem.mem_req <= 1'b0;
                        mem_err     <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WB: begin
                    wb_en   <= 1'b1;
                    wb_addr <= rd_q;
                    wb_data <= rdata_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for single-cycle ops plus
// hand-written LD/ST, timeout, HLT and reset-during-access sequences.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex;
    logic [5:0]  op_ex;
    logic [2:0]  rd_ex;
    logic [15:0] ans_ex;
    logic [15:0] DM_data;
    logic [1:0]  flag_ex;
    logic        stall;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [1:0]  flag_wb;
    logic        halt;
    logic        mem_err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_wb_stage_if #(.ADDR_W(8)) mif ();

    mem_wb_stage #(.ADDR_W(8), .REG_AW(3), .TIMEOUT(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_ex (valid_ex),
        .op_ex    (op_ex),
        .rd_ex    (rd_ex),
        .ans_ex   (ans_ex),
        .DM_data  (DM_data),
        .flag_ex  (flag_ex),
        .stall    (stall),
        .mem      (mif),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flag_wb  (flag_wb),
        .halt     (halt),
        .mem_err  (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [2:0]  rd;
        logic [15:0] ans;
        logic [1:0]  flag;
        logic        en;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [1:0]  fwb;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [2:0] rd,
                         input logic [15:0] ans, input logic [15:0] dm, input logic [1:0] fl);
        valid_ex = v;
        op_ex    = op;
        rd_ex    = rd;
        ans_ex   = ans;
        DM_data  = dm;
        flag_ex  = fl;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " wb_en"},     wb_en, 0);
        chk({tag, " wb_addr"},   wb_addr, 0);
        chk({tag, " wb_data"},   wb_data, 0);
        chk({tag, " flag_wb"},   flag_wb, 0);
        chk({tag, " halt"},      halt, 0);
        chk({tag, " mem_err"},   mem_err, 0);
        chk({tag, " mem_req"},   mif.mem_req, 0);
        chk({tag, " mem_we"},    mif.mem_we, 0);
        chk({tag, " mem_addr"},  mif.mem_addr, 0);
        chk({tag, " mem_wdata"}, mif.mem_wdata, 0);
        chk({tag, " stall"},     stall, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen_wb;

        vecs[0]  = '{1'b1, 6'h00, 3'd3, 16'h1234, 2'd0, 1'b1, 3'd3, 16'h1234, 2'd0};
        vecs[1]  = '{1'b0, 6'h00, 3'd5, 16'hFFFF, 2'd3, 1'b0, 3'd3, 16'h1234, 2'd0};
        vecs[2]  = '{1'b1, 6'h01, 3'd1, 16'h0001, 2'd2, 1'b1, 3'd1, 16'h0001, 2'd2};
        vecs[3]  = '{1'b1, 6'h0A, 3'd7, 16'h00FF, 2'd1, 1'b1, 3'd7, 16'h00FF, 2'd1};
        vecs[4]  = '{1'b1, 6'h1B, 3'd2, 16'h8000, 2'd0, 1'b1, 3'd2, 16'h8000, 2'd0};
        vecs[5]  = '{1'b1, 6'h03, 3'd6, 16'hDEAD, 2'd3, 1'b0, 3'd2, 16'h8000, 2'd3};
        vecs[6]  = '{1'b1, 6'h1F, 3'd4, 16'h5555, 2'd1, 1'b0, 3'd2, 16'h8000, 2'd1};
        vecs[7]  = '{1'b1, 6'h16, 3'd4, 16'h0042, 2'd0, 1'b1, 3'd4, 16'h0042, 2'd0};
        vecs[8]  = '{1'b1, 6'h0F, 3'd0, 16'hAAAA, 2'd2, 1'b1, 3'd0, 16'hAAAA, 2'd2};
        vecs[9]  = '{1'b1, 6'h10, 3'd1, 16'h1111, 2'd0, 1'b0, 3'd0, 16'hAAAA, 2'd0};
        vecs[10] = '{1'b1, 6'h19, 3'd5, 16'h0F0F, 2'd1, 1'b1, 3'd5, 16'h0F0F, 2'd1};
        vecs[11] = '{1'b0, 6'h00, 3'd6, 16'h7777, 2'd2, 1'b0, 3'd5, 16'h0F0F, 2'd1};

        reset = 1'b0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        drive(1'b0, 6'h00, 3'd0, 16'h0000, 16'h0000, 2'd0);
        step();
        step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // Single-cycle ops, back-to-back where valid is held high
        for (int unsigned i = 0; i < 12; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].rd, vecs[i].ans, 16'h0000, vecs[i].flag);
            chk($sformatf("vec%0d stall", i), stall, 0);
            step();
            chk($sformatf("vec%0d wb_en", i),   wb_en,   vecs[i].en);
            chk($sformatf("vec%0d wb_addr", i), wb_addr, vecs[i].addr);
            chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].data);
            chk($sformatf("vec%0d flag_wb", i), flag_wb, vecs[i].fwb);
            chk($sformatf("vec%0d mem_req", i), mif.mem_req, 0);
        end

        // LD acknowledged in the third ACCESS cycle
        drive(1'b1, 6'h14, 3'd6, 16'h0040, 16'h1111, 2'd2);
        chk("ld stall at accept", stall, 1);
        step();
        drive(1'b0, 6'h00, 3'd0, 16'h0000, 16'h0000, 2'd0);
        chk("ld req c1", mif.mem_req, 1);
        chk("ld we", mif.mem_we, 0);
        chk("ld addr", mif.mem_addr, 8'h40);
        chk("ld stall c1", stall, 1);
        chk("ld flag_wb", flag_wb, 2);
        step();
        chk("ld req c2", mif.mem_req, 1);
        step();
        chk("ld req c3", mif.mem_req, 1);
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 16'hBEEF;
        step();
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 16'h0000;
        chk("ld req after ack", mif.mem_req, 0);
        chk("ld wb_en early", wb_en, 0);
        chk("ld stall in wb", stall, 1);
        step();
        chk("ld wb_en", wb_en, 1);
        chk("ld wb_addr", wb_addr, 6);
        chk("ld wb_data", wb_data, 16'hBEEF);
        chk("ld stall after", stall, 0);
        step();
        chk("ld wb_en pulse", wb_en, 0);

        // ST acknowledged in the first ACCESS cycle
        drive(1'b1, 6'h15, 3'd1, 16'h0012, 16'hA5A5, 2'd1);
        chk("st stall at accept", stall, 1);
        step();
        drive(1'b0, 6'h00, 3'd0, 16'h0000, 16'h0000, 2'd0);
        chk("st req", mif.mem_req, 1);
        chk("st we", mif.mem_we, 1);
        chk("st addr", mif.mem_addr, 8'h12);
        chk("st wdata", mif.mem_wdata, 16'hA5A5);
        mif.mem_ack = 1'b1;
        step();
        mif.mem_ack = 1'b0;
        chk("st req after ack", mif.mem_req, 0);
        chk("st stall idle", stall, 0);
        chk("st wb_en", wb_en, 0);
        mif.mem_ack = 1'b1;
        step();
        mif.mem_ack = 1'b0;
        chk("stray ack wb_en", wb_en, 0);
        chk("stray ack req", mif.mem_req, 0);

        // LD acknowledged in the last cycle before timeout: ack must win
        drive(1'b1, 6'h14, 3'd3, 16'h0055, 16'h0000, 2'd0);
        step();
        drive(1'b0, 6'h00, 3'd0, 16'h0000, 16'h0000, 2'd0);
        for (int unsigned c = 1; c < 15; c++) step();
        chk("edge req c15", mif.mem_req, 1);
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 16'h7E57;
        step();
        mif.mem_ack = 1'b0;
        step();
        chk("edge wb_en", wb_en, 1);
        chk("edge wb_data", wb_data, 16'h7E57);
        chk("edge mem_err", mem_err, 0);

        // LD never acknowledged: abort after TIMEOUT ACCESS cycles
        drive(1'b1, 6'h14, 3'd2, 16'h0077, 16'h0000, 2'd0);
        step();
        drive(1'b0, 6'h00, 3'd0, 16'h0000, 16'h0000, 2'd0);
        n = 0;
        seen_wb = 1'b0;
        while (mif.mem_req && n < 40) begin
            n++;
            step();
            if (wb_en) seen_wb = 1'b1;
        end
        chk("to req cycles", n, 15);
        chk("to mem_err", mem_err, 1);
        chk("to no wb", seen_wb, 0);
        chk("to stall idle", stall, 0);
        drive(1'b1, 6'h00, 3'd1, 16'h0BAD, 16'h0000, 2'd0);
        step();
        drive(1'b0, 6'h00, 3'd0, 16'h0000, 16'h0000, 2'd0);
        chk("to next add wb_en", wb_en, 1);
        chk("to next add data", wb_data, 16'h0BAD);
        chk("to mem_err sticky", mem_err, 1);

        // Reset pulsed while a LD is pending; the late ack must be ignored
        drive(1'b1, 6'h14, 3'd4, 16'h0033, 16'h0000, 2'd0);
        step();
        drive(1'b0, 6'h00, 3'd0, 16'h0000, 16'h0000, 2'd0);
        chk("rst ld req", mif.mem_req, 1);
        reset = 1'b0;
        #1;
        chk("rst req drop", mif.mem_req, 0);
        chk("rst mem_err clr", mem_err, 0);
        step();
        reset = 1'b1;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 16'h9999;
        step();
        mif.mem_ack = 1'b0;
        chk("rst ack req", mif.mem_req, 0);
        chk("rst ack wb_en", wb_en, 0);
        step();
        chk("rst late wb_en", wb_en, 0);
        chk("rst wb_data", wb_data, 0);

        // HLT then ADD: nothing written, halt sticky until reset
        drive(1'b1, 6'h11, 3'd0, 16'h0000, 16'h0000, 2'd3);
        chk("hlt stall at accept", stall, 1);
        step();
        chk("hlt halt", halt, 1);
        chk("hlt flag_wb", flag_wb, 3);
        drive(1'b1, 6'h00, 3'd5, 16'h1357, 16'h0000, 2'd1);
        seen_wb = 1'b0;
        for (int unsigned c = 0; c < 4; c++) begin
            step();
            if (wb_en) seen_wb = 1'b1;
        end
        chk("hlt stall", stall, 1);
        chk("hlt no wb", seen_wb, 0);
        chk("hlt flag ignored", flag_wb, 3);
        drive(1'b0, 6'h00, 3'd0, 16'h0000, 16'h0000, 2'd0);
        reset = 1'b0;
        #1;
        check_all_zero("hlt reset");
        step();
        reset = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
